taillight_sequencer: RTL and testbench

Sequences the tail-light LED bank of the project 3 turn-signal controller. It takes the 4-bit state code produced by the state decider and a one-cycle step strobe derived from the 1 Hz divider output. From these it produces the registered 10-bit LED pattern: sweeping turn signals, steady brake lamps, and flashing hazards. It also exports its mode and phase for the seven-segment display.

---
 rtl/taillight_sequencer_pkg.sv | 63 ++++++
 rtl/lamp_pattern.sv | 36 +++
 rtl/taillight_sequencer.sv | 67 ++++++
 tb/tb_taillight_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/taillight_sequencer_pkg.sv
// Purpose: shared mode encodings, state-code constants and sweep patterns for the tail-light sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package taillight_sequencer_pkg;

    // Decoded lamp modes; the encoding is also what the HEX display shows.
    typedef enum logic [2:0] {
        MODE_IDLE    = 3'd0,
        MODE_RIGHT   = 3'd1,
        MODE_LEFT    = 3'd2,
        MODE_BRAKE   = 3'd3,
        MODE_BRAKE_R = 3'd4,
        MODE_BRAKE_L = 3'd5,
        MODE_HAZARD  = 3'd6
    } mode_t;

    // State codes from the decider (any code with bit 3 set means hazard).
    localparam logic [3:0] ST_IDLE_A  = 4'b0000;
    localparam logic [3:0] ST_IDLE_B  = 4'b0010;
    localparam logic [3:0] ST_RIGHT   = 4'b0001;
    localparam logic [3:0] ST_LEFT    = 4'b0011;
    localparam logic [3:0] ST_BRAKE_A = 4'b0100;
    localparam logic [3:0] ST_BRAKE_B = 4'b0110;
    localparam logic [3:0] ST_BRAKE_R = 4'b0101;
    localparam logic [3:0] ST_BRAKE_L = 4'b0111;

    // Turn-group sweep, bit 0 is the innermost lamp.
    localparam logic [2:0] SWEEP_P0 = 3'b001;
    localparam logic [2:0] SWEEP_P1 = 3'b011;
    localparam logic [2:0] SWEEP_P2 = 3'b111;
    localparam logic [2:0] SWEEP_P3 = 3'b000;

    function automatic mode_t decode_state(input logic [3:0] code);
        mode_t m;
        case (code)
            ST_IDLE_A, ST_IDLE_B:   m = MODE_IDLE;
            ST_RIGHT:               m = MODE_RIGHT;
            ST_LEFT:                m = MODE_LEFT;
            ST_BRAKE_A, ST_BRAKE_B: m = MODE_BRAKE;
            ST_BRAKE_R:             m = MODE_BRAKE_R;
            ST_BRAKE_L:             m = MODE_BRAKE_L;
            default:                m = MODE_HAZARD;   // 1xxx
        endcase
        return m;
    endfunction

    // Modes whose phase advances on tick; IDLE and BRAKE stay parked at phase 0.
    function automatic logic is_sequencing(input mode_t m);
        return (m != MODE_IDLE) && (m != MODE_BRAKE);
    endfunction

    function automatic logic [2:0] sweep_bits(input logic [1:0] phase);
        logic [2:0] s;
        case (phase)
            2'd0:    s = SWEEP_P0;
            2'd1:    s = SWEEP_P1;
            2'd2:    s = SWEEP_P2;
            default: s = SWEEP_P3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lamp_pattern.sv
// Purpose: combinational (mode, phase) -> 10-bit tail-light pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: mode/phase in; pattern[9:7] left group (bit 7 inner), [6:3] brake bar, [2:0] right group (bit 2 inner).
module lamp_pattern
    import taillight_sequencer_pkg::*;
(
    input  mode_t       mode,
    input  logic [1:0]  phase,
    output logic [9:0]  pattern
);

    logic [2:0] sweep;
    logic [2:0] right_grp;

    always_comb begin
        sweep = sweep_bits(phase);
        // Right group grows outward from led[2], so its bit order is mirrored.
        right_grp = {sweep[0], sweep[1], sweep[2]};
    end

    always_comb begin
        pattern = '0;
        case (mode)
            MODE_IDLE:    pattern = '0;
            MODE_RIGHT:   pattern = {3'b000, 4'b0000, right_grp};
            MODE_LEFT:    pattern = {sweep, 4'b0000, 3'b000};
            MODE_BRAKE:   pattern = '1;
            MODE_BRAKE_R: pattern = {3'b111, 4'b1111, right_grp};
            MODE_BRAKE_L: pattern = {sweep, 4'b1111, 3'b111};
            MODE_HAZARD:  pattern = phase[0] ? 10'b0 : 10'b11_1111_1111;
            default:      pattern = '0;
        endcase
    end

endmodule

// File: rtl/taillight_sequencer.sv
// Purpose: decode turn/brake/hazard state, step the sweep phase on tick, drive the registered LED bank.
// Latency: 1 cycle from state/tick sampled at an edge to led/mode/phase updated after that edge.
// Backpressure: none; every tick cycle advances the phase (no edge detection on tick).
// Ports: clk, rst (sync active-high), tick (1-cycle strobe), state[3:0]; led[9:0], mode[2:0], phase[1:0].
module taillight_sequencer
    import taillight_sequencer_pkg::*;
#(
    parameter int STEPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [3:0]  state,
    output logic [9:0]  led,
    output logic [2:0]  mode,
    output logic [1:0]  phase
);

    localparam logic [1:0] PHASE_MAX = 2'(STEPS - 1);

    mode_t      mode_q;
    mode_t      mode_n;
    mode_t      mode_dec;
    logic [1:0] phase_q;
    logic [1:0] phase_n;
    logic [9:0] led_q;
    logic [9:0] led_n;

    always_comb begin
        mode_dec = decode_state(state);
        mode_n   = mode_q;
        phase_n  = phase_q;
        if (mode_dec != mode_q) begin
            // A mode change restarts the sweep and swallows any tick this cycle.
            mode_n  = mode_dec;
            phase_n = 2'd0;
        end else if (!is_sequencing(mode_q)) begin
            phase_n = 2'd0;
        end else if (tick) begin
            phase_n = (phase_q == PHASE_MAX) ? 2'd0 : phase_q + 2'd1;
        end
    end

    // Pattern is derived from the next mode/phase so the registered led never lags mode/phase.
    lamp_pattern u_lamp_pattern (
        .mode    (mode_n),
        .phase   (phase_n),
        .pattern (led_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_IDLE;
            phase_q <= 2'd0;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_n;
            phase_q <= phase_n;
            led_q   <= led_n;
        end
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_taillight_sequencer.sv
module tb_taillight_sequencer;

    localparam int STEPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] state;
    logic [9:0] led;
    logic [2:0] mode;
    logic [1:0] phase;

    taillight_sequencer #(.STEPS(STEPS)) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .state (state),
        .led   (led),
        .mode  (mode),
        .phase (phase)
    );

    always #50 clk = ~clk;

    typedef struct {
        int         mode;
        int         phase;
        logic [9:0] led;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   stim_done = 0;

    // Reference model state (what the outputs must read after the next edge).
    int    m_mode  = 0;
    int    m_phase = 0;
    string tname   = "init";

    function automatic int ref_decode(input int s);
        if (s >= 8) return 6;
        case (s)
            1: return 1;
            3: return 2;
            4, 6: return 3;
            5: return 4;
            7: return 5;
            default: return 0;
        endcase
    endfunction

    // Lamps lit in a turn group: phase 0..2 -> 1..3 lamps, phase 3 -> none.
    function automatic logic [9:0] ref_led(input int m, input int p);
        logic [9:0] l;
        int n;
        n = (p == 3) ? 0 : p + 1;
        l = '0;
        if (m == 3 || m == 4 || m == 5) l = '1;
        if (m == 6) l = (p % 2 == 0) ? '1 : '0;
        if (m == 1 || m == 4)
            for (int i = 0; i < 3; i++) l[2 - i] = (i < n);
        if (m == 2 || m == 5)
            for (int i = 0; i < 3; i++) l[7 + i] = (i < n);
        return l;
    endfunction

    task automatic step(input logic r, input logic [3:0] s, input logic t);
        exp_t e;
        int nm;
        @(negedge clk);
        rst = r; state = s; tick = t;
        if (r) begin
            m_mode = 0; m_phase = 0;
        end else begin
            nm = ref_decode(int'(s));
            if (nm != m_mode) begin
                m_mode = nm; m_phase = 0;
            end else if (t && m_mode != 0 && m_mode != 3) begin
                m_phase = (m_phase + 1) % STEPS;
            end
        end
        e.mode = m_mode; e.phase = m_phase; e.led = ref_led(m_mode, m_phase); e.name = tname;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge produces a new output word; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(mode) == e.mode && int'(phase) == e.phase && led === e.led)
                    passed++;
                else
                    $display("FAIL %s: got led=%b mode=%0d phase=%0d, want led=%b mode=%0d phase=%0d",
                             e.name, led, mode, phase, e.led, e.mode, e.phase);
            end
        end
    end

    initial begin
        logic [3:0] cur_s;
        rst = 1'b1; tick = 1'b0; state = 4'b0000;

        tname = "reset";
        step(1, 4'b1000, 1);
        step(1, 4'b1000, 1);

        tname = "right_sweep";
        step(0, 4'b0001, 0);
        repeat (4) begin step(0, 4'b0001, 1); step(0, 4'b0001, 0); end
        step(0, 4'b0001, 1);

        tname = "brake_left";
        step(0, 4'b0111, 0);
        repeat (3) begin step(0, 4'b0111, 0); step(0, 4'b0111, 1); end

        tname = "hazard";
        step(0, 4'b1010, 0);
        repeat (4) begin step(0, 4'b1010, 1); step(0, 4'b1010, 0); end

        tname = "simultaneous";
        step(0, 4'b0001, 0);
        step(0, 4'b0001, 1);
        step(0, 4'b0001, 1);
        step(0, 4'b0011, 1);

        tname = "reset_mid";
        step(0, 4'b0011, 1);
        step(1, 4'b0011, 1);
        step(0, 4'b0100, 0);
        repeat (3) step(0, 4'b0100, 1);

        tname = "tick_held";
        step(0, 4'b0101, 0);
        repeat (6) step(0, 4'b0101, 1);

        tname = "idle_codes";
        step(0, 4'b0010, 1);
        step(0, 4'b0000, 1);
        step(0, 4'b0110, 1);

        tname = "random";
        cur_s = 4'b0001;
        repeat (600) begin
            if ($urandom_range(0, 99) < 15) cur_s = 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 2, cur_s, $urandom_range(0, 99) < 35);
        end

        step(0, cur_s, 0);
        repeat (3) @(negedge clk);
        stim_done = 1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!stim_done && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        checks++;
        if (stim_done && exp_q.size() == 0)
            passed++;
        else
            $display("FAIL drain: got done=%0d pending=%0d, want done=1 pending=0", stim_done, exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
